// File: rtl/gac_pkg.sv
// Shared definitions for the gac packet generator: config map, opcodes,
// MD field offsets, FSM encoding and the MD packing helper.
package gac_pkg;

    localparam int MD_W  = 256;
    localparam int PHV_W = 1024;
    localparam int CFG_W = 134;

    localparam logic [2:0] CFG_WR   = 3'b010;
    localparam logic [2:0] CFG_RD   = 3'b001;
    localparam logic [3:0] CFG_RESP = 4'b1011;

    localparam logic [31:0] ADDR_PROTO = 32'h7000_0010;
    localparam logic [31:0] ADDR_LEN   = 32'h7000_0011;
    localparam logic [31:0] ADDR_NUM   = 32'h7000_0012;
    localparam logic [31:0] ADDR_GAP   = 32'h7000_0013;
    localparam logic [31:0] ADDR_CTRL  = 32'h7000_0014;
    localparam logic [31:0] ADDR_CNT   = 32'h7000_0018;
    localparam logic [31:0] ADDR_STAT  = 32'h7000_0019;

    localparam int MD_LEN_LSB   = 96;
    localparam int MD_SMID_LSB  = 88;
    localparam int MD_DMID_LSB  = 80;
    localparam int MD_PROTO_LSB = 72;
    localparam int MD_SEQ_LSB   = 32;
    localparam int MD_TS_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } gac_state_t;

    function automatic logic [MD_W-1:0] build_md(
        input logic [11:0] len,
        input logic [7:0]  smid,
        input logic [7:0]  dmid,
        input logic [7:0]  proto,
        input logic [31:0] seq,
        input logic [31:0] ts
    );
        logic [MD_W-1:0] md;
        md = '0;
        md[MD_LEN_LSB   +: 12] = len;
        md[MD_SMID_LSB  +: 8]  = smid;
        md[MD_DMID_LSB  +: 8]  = dmid;
        md[MD_PROTO_LSB +: 8]  = proto;
        md[MD_SEQ_LSB   +: 32] = seq;
        md[MD_TS_LSB    +: 32] = ts;
        return md;
    endfunction

endpackage

// File: rtl/gac_cfg_regs.sv
// Config chain slice: decodes accepted words, holds the run parameters,
// answers status reads and forwards every accepted word one cycle later.
import gac_pkg::*;

module gac_cfg_regs (
    input  logic             clk,
    input  logic             rst,
    input  logic [CFG_W-1:0] cin_data,
    input  logic             cin_data_wr,
    input  logic             cin_ready,
    output logic             cout_ready,
    output logic [CFG_W-1:0] cout_data,
    output logic             cout_data_wr,
    input  logic [31:0]      sent_cnt,
    input  logic             sent_start,
    input  logic             sent_end,
    output logic [7:0]       proto,
    output logic [11:0]      pkt_len,
    output logic [31:0]      pkt_num,
    output logic [15:0]      gap,
    output logic             start,
    output logic             abort
);

    logic             accept;
    logic             wr_hit;
    logic [2:0]       opcode;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [CFG_W-1:0] fwd_next;
    logic [CFG_W-1:0] cout_data_reg;
    logic             cout_data_wr_reg;
    logic [7:0]       proto_reg;
    logic [11:0]      pkt_len_reg;
    logic [31:0]      pkt_num_reg;
    logic [15:0]      gap_reg;

    assign accept = cin_data_wr && cin_ready;
    assign opcode = cin_data[126:124];
    assign addr   = cin_data[95:64];
    assign wdata  = cin_data[31:0];
    assign wr_hit = accept && (opcode == CFG_WR);

    // Control bits are pulses for the FSM in the acceptance cycle; nothing is stored.
    assign start = wr_hit && (addr == ADDR_CTRL) && wdata[0];
    assign abort = wr_hit && (addr == ADDR_CTRL) && wdata[1];

    always_comb begin
        fwd_next = cin_data;
        if (accept && (opcode == CFG_RD)) begin
            case (addr)
                ADDR_CNT:  fwd_next = {cin_data[133:128], CFG_RESP, cin_data[123:32], sent_cnt};
                ADDR_STAT: fwd_next = {cin_data[133:128], CFG_RESP, cin_data[123:32],
                                       30'b0, sent_end, sent_start};
                default:   fwd_next = cin_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cout_data_reg    <= '0;
            cout_data_wr_reg <= 1'b0;
            proto_reg        <= '0;
            pkt_len_reg      <= '0;
            pkt_num_reg      <= '0;
            gap_reg          <= '0;
        end else begin
            cout_data_wr_reg <= accept;
            if (accept) begin
                cout_data_reg <= fwd_next;
            end
            if (wr_hit) begin
                case (addr)
                    ADDR_PROTO: proto_reg   <= wdata[7:0];
                    ADDR_LEN:   pkt_len_reg <= wdata[11:0];
                    ADDR_NUM:   pkt_num_reg <= wdata;
                    ADDR_GAP:   gap_reg     <= wdata[15:0];
                    default:    ;
                endcase
            end
        end
    end

    assign cout_ready   = cin_ready;
    assign cout_data    = cout_data_reg;
    assign cout_data_wr = cout_data_wr_reg;
    assign proto        = proto_reg;
    assign pkt_len      = pkt_len_reg;
    assign pkt_num      = pkt_num_reg;
    assign gap          = gap_reg;

endmodule

// File: rtl/gac_pkt_gen.sv
// Packet generator toward scm: run FSM, free-running timestamp and MD/PHV
// formatting, with the config register slice instantiated alongside.
import gac_pkg::*;

module gac_pkt_gen #(
    parameter logic [7:0] SMID    = 8'd5,
    parameter logic [7:0] DST_MID = 8'd7
) (
    input  logic              clk,
    input  logic              rst,
    output logic [MD_W-1:0]   out_gac_md,
    output logic              out_gac_md_wr,
    input  logic              in_gac_md_alf,
    output logic [PHV_W-1:0]  out_gac_phv,
    output logic              out_gac_phv_wr,
    input  logic              in_gac_phv_alf,
    output logic              gac2scm_sent_start,
    output logic              gac2scm_sent_end,
    input  logic [CFG_W-1:0]  cin_gac_data,
    input  logic              cin_gac_data_wr,
    output logic              cout_gac_ready,
    output logic [CFG_W-1:0]  cout_gac_data,
    output logic              cout_gac_data_wr,
    input  logic              cin_gac_ready
);

    gac_state_t       state_reg, state_next;
    logic [7:0]       proto;
    logic [11:0]      pkt_len;
    logic [31:0]      pkt_num;
    logic [15:0]      gap;
    logic             start, abort;
    logic [31:0]      ts_reg;
    logic [31:0]      seq_reg;
    logic [31:0]      sent_cnt_reg;
    logic [31:0]      run_num_reg;
    logic [15:0]      gap_cnt_reg;
    logic [MD_W-1:0]  md_reg;
    logic [31:0]      phv_seq_reg;
    logic             md_wr_reg;
    logic             alf;
    logic             idle_like;
    logic             launch;
    logic             fire;
    logic             last;
    logic             sent_start, sent_end;

    gac_cfg_regs u_cfg (
        .clk          (clk),
        .rst          (rst),
        .cin_data     (cin_gac_data),
        .cin_data_wr  (cin_gac_data_wr),
        .cin_ready    (cin_gac_ready),
        .cout_ready   (cout_gac_ready),
        .cout_data    (cout_gac_data),
        .cout_data_wr (cout_gac_data_wr),
        .sent_cnt     (sent_cnt_reg),
        .sent_start   (sent_start),
        .sent_end     (sent_end),
        .proto        (proto),
        .pkt_len      (pkt_len),
        .pkt_num      (pkt_num),
        .gap          (gap),
        .start        (start),
        .abort        (abort)
    );

    assign alf       = in_gac_md_alf || in_gac_phv_alf;
    assign idle_like = (state_reg == IDLE) || (state_reg == DONE);
    assign launch    = idle_like && start && !abort && (pkt_num != 32'd0);
    assign fire      = (state_reg == SEND) && !abort && !alf;
    assign last      = (sent_cnt_reg + 32'd1) == run_num_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_next = (pkt_num == 32'd0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_next = DONE;
                end else if (!alf) begin
                    if (last) begin
                        state_next = DONE;
                    end else if (gap != 16'd0) begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = DONE;
                end else if (gap_cnt_reg == 16'd1) begin
                    state_next = SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The strobe is registered, so the window keeps sent_start up through the
    // final strobe cycle and only then hands over to sent_end.
    always_comb begin
        sent_start = md_wr_reg || (state_reg == SEND) || (state_reg == GAP);
        sent_end   = (state_reg == DONE) && !md_wr_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_reg       <= '0;
            seq_reg      <= '0;
            sent_cnt_reg <= '0;
            run_num_reg  <= '0;
            gap_cnt_reg  <= '0;
            md_reg       <= '0;
            phv_seq_reg  <= '0;
            md_wr_reg    <= 1'b0;
        end else begin
            ts_reg    <= ts_reg + 32'd1;
            md_wr_reg <= fire;
            if (launch) begin
                seq_reg      <= '0;
                sent_cnt_reg <= '0;
                run_num_reg  <= pkt_num;
            end
            if (fire) begin
                // Timestamp is the value the counter shows while the strobe is high.
                md_reg       <= build_md(pkt_len, SMID, DST_MID, proto, seq_reg, ts_reg + 32'd1);
                phv_seq_reg  <= seq_reg;
                seq_reg      <= seq_reg + 32'd1;
                sent_cnt_reg <= sent_cnt_reg + 32'd1;
                gap_cnt_reg  <= gap;
            end else if (state_reg == GAP) begin
                gap_cnt_reg <= gap_cnt_reg - 16'd1;
            end
        end
    end

    assign out_gac_md         = md_reg;
    assign out_gac_md_wr      = md_wr_reg;
    assign out_gac_phv        = {{(PHV_W-32){1'b0}}, phv_seq_reg};
    assign out_gac_phv_wr     = md_wr_reg;
    assign gac2scm_sent_start = sent_start;
    assign gac2scm_sent_end   = sent_end;

endmodule

// File: tb/tb_gac_pkt_gen.sv
// Randomized bench for gac_pkt_gen: strobe timing, MD/PHV content and the
// window signals are predicted from the run rules and an alf pattern per run.
`timescale 1ns/1ps
module tb_gac_pkt_gen;

    localparam logic [2:0]  OP_WR   = 3'b010;
    localparam logic [2:0]  OP_RD   = 3'b001;
    localparam logic [31:0] A_PROTO = 32'h7000_0010;
    localparam logic [31:0] A_LEN   = 32'h7000_0011;
    localparam logic [31:0] A_NUM   = 32'h7000_0012;
    localparam logic [31:0] A_GAP   = 32'h7000_0013;
    localparam logic [31:0] A_CTRL  = 32'h7000_0014;
    localparam logic [31:0] A_CNT   = 32'h7000_0018;
    localparam logic [31:0] A_STAT  = 32'h7000_0019;
    localparam logic [31:0] A_UNK   = 32'h7000_0000;
    localparam int ARR = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [255:0]  out_gac_md;
    logic          out_gac_md_wr;
    logic          in_gac_md_alf = 1'b0;
    logic [1023:0] out_gac_phv;
    logic          out_gac_phv_wr;
    logic          in_gac_phv_alf = 1'b0;
    logic          gac2scm_sent_start;
    logic          gac2scm_sent_end;
    logic [133:0]  cin_gac_data = '0;
    logic          cin_gac_data_wr = 1'b0;
    logic          cout_gac_ready;
    logic [133:0]  cout_gac_data;
    logic          cout_gac_data_wr;
    logic          cin_gac_ready = 1'b1;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] ts_model = '0;
    int          cnt_model = 0;

    int           seen_cyc[$];
    logic [255:0] seen_md[$];
    logic [31:0]  seen_phv[$];
    logic         seen_hi[$];

    gac_pkt_gen dut (
        .clk                (clk),
        .rst                (rst),
        .out_gac_md         (out_gac_md),
        .out_gac_md_wr      (out_gac_md_wr),
        .in_gac_md_alf      (in_gac_md_alf),
        .out_gac_phv        (out_gac_phv),
        .out_gac_phv_wr     (out_gac_phv_wr),
        .in_gac_phv_alf     (in_gac_phv_alf),
        .gac2scm_sent_start (gac2scm_sent_start),
        .gac2scm_sent_end   (gac2scm_sent_end),
        .cin_gac_data       (cin_gac_data),
        .cin_gac_data_wr    (cin_gac_data_wr),
        .cout_gac_ready     (cout_gac_ready),
        .cout_gac_data      (cout_gac_data),
        .cout_gac_data_wr   (cout_gac_data_wr),
        .cin_gac_ready      (cin_gac_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ts_model <= rst ? 32'd0 : ts_model + 32'd1;
    end

    always @(negedge clk) begin
        check_val("win_excl", 256'(gac2scm_sent_start & gac2scm_sent_end), 256'(0));
        if (out_gac_md_wr || out_gac_phv_wr) begin
            check_val("wr_pair", 256'(out_gac_phv_wr), 256'(out_gac_md_wr));
            seen_cyc.push_back(cyc);
            seen_md.push_back(out_gac_md);
            seen_phv.push_back(out_gac_phv[31:0]);
            seen_hi.push_back(|out_gac_phv[1023:32]);
        end
    end

    function automatic logic [133:0] mkword(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] data);
        logic [133:0] w;
        w[31:0]    = data;
        w[63:32]   = $urandom;
        w[95:64]   = addr;
        w[123:96]  = 28'($urandom);
        w[126:124] = op;
        w[127]     = 1'($urandom);
        w[133:128] = 6'($urandom);
        return w;
    endfunction

    function automatic logic [255:0] exp_md(input logic [11:0] len, input logic [7:0] proto,
                                            input logic [31:0] seq, input logic [31:0] ts);
        return {147'd0, 1'b0, len, 8'd5, 8'd7, proto, 8'd0, seq, ts};
    endfunction

    task automatic clear_seen();
        seen_cyc.delete();
        seen_md.delete();
        seen_phv.delete();
        seen_hi.delete();
    endtask

    task automatic cfg_xfer(input logic [133:0] w, input logic rdy, input logic [133:0] exp,
                            input string tag);
        cin_gac_data    = w;
        cin_gac_data_wr = 1'b1;
        cin_gac_ready   = rdy;
        #1;
        check_val({tag, "_rdy"}, 256'(cout_gac_ready), 256'(rdy));
        @(negedge clk);
        cin_gac_data_wr = 1'b0;
        cin_gac_ready   = 1'b1;
        check_val({tag, "_vld"}, 256'(cout_gac_data_wr), 256'(rdy));
        if (rdy) check_val({tag, "_data"}, 256'(cout_gac_data), 256'(exp));
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        logic [133:0] w;
        w = mkword(OP_WR, addr, data);
        cfg_xfer(w, 1'b1, w, "cfg_wr");
    endtask

    task automatic cfg_read(input logic [31:0] addr, input logic [31:0] value, input logic hit,
                            input string tag);
        logic [133:0] w;
        logic [133:0] exp;
        w   = mkword(OP_RD, addr, 32'($urandom));
        exp = hit ? {w[133:128], 4'b1011, w[123:32], value} : w;
        cfg_xfer(w, 1'b1, exp, tag);
    endtask

    // Start at relative cycle 0; the model walks the alf pattern: a pair may
    // go out in any SEND cycle with alf low, and after each pair the next
    // opportunity is gap+1 cycles later. Strobes appear one cycle after.
    task automatic do_run(input string name, input logic [7:0] proto, input logic [11:0] len,
                          input int num, input int gap, input int abort_off,
                          input int restart_off, input int alf_pct, input int hold_at);
        bit          alf_arr [ARR];
        int          fires[$];
        int          c, end_rel, first_end, s, nf;
        logic [31:0] ts_s;
        logic        sel;
        cfg_write(A_PROTO, 32'(proto));
        cfg_write(A_LEN, 32'(len));
        cfg_write(A_NUM, 32'(num));
        cfg_write(A_GAP, 32'(gap));
        for (int i = 0; i < ARR; i++) begin
            alf_arr[i] = (i < ARR - 100) && (int'($urandom_range(99)) < alf_pct);
            if (hold_at > 0 && i >= hold_at && i < hold_at + 5) alf_arr[i] = 1'b1;
        end
        c = 1;
        while (num != 0 && fires.size() < num && c < ARR && !(abort_off > 0 && c >= abort_off)) begin
            if (!alf_arr[c]) begin
                fires.push_back(c);
                c += gap + 1;
            end else begin
                c++;
            end
        end
        if (num == 0) end_rel = 1;
        else if (fires.size() == num) end_rel = fires[$] + 2;
        else end_rel = abort_off + 1;

        clear_seen();
        s         = cyc;
        ts_s      = ts_model;
        first_end = -1;
        for (int rel = 0; rel < end_rel + 6; rel++) begin
            if (rel >= 1 && first_end < 0 && gac2scm_sent_end) first_end = rel;
            if (rel == 1) check_val({name, "_start_lvl"}, 256'(gac2scm_sent_start), 256'(num != 0));
            sel             = 1'($urandom);
            in_gac_md_alf   = alf_arr[rel] & sel;
            in_gac_phv_alf  = alf_arr[rel] & ~sel;
            cin_gac_data_wr = 1'b0;
            if (rel == 0 || rel == restart_off) begin
                cin_gac_data    = mkword(OP_WR, A_CTRL, 32'h1);
                cin_gac_data_wr = 1'b1;
            end
            if (rel == abort_off) begin
                cin_gac_data    = mkword(OP_WR, A_CTRL, 32'h2);
                cin_gac_data_wr = 1'b1;
            end
            @(negedge clk);
        end
        in_gac_md_alf   = 1'b0;
        in_gac_phv_alf  = 1'b0;
        cin_gac_data_wr = 1'b0;

        check_val({name, "_count"}, 256'(seen_cyc.size()), 256'(fires.size()));
        nf = (seen_cyc.size() < fires.size()) ? seen_cyc.size() : fires.size();
        for (int k = 0; k < nf; k++) begin
            check_val({name, "_cyc"}, 256'(seen_cyc[k]), 256'(s + fires[k] + 1));
            check_val({name, "_md"}, seen_md[k],
                      exp_md(len, proto, 32'(k), ts_s + 32'(fires[k] + 1)));
            check_val({name, "_phv"}, 256'(seen_phv[k]), 256'(k));
            check_val({name, "_phv_hi"}, 256'(seen_hi[k]), 256'(0));
        end
        check_val({name, "_end_rise"}, 256'(first_end), 256'(end_rel));
        if (num != 0) cnt_model = fires.size();
        cfg_read(A_CNT, 32'(cnt_model), 1'b1, {name, "_rd_cnt"});
        cfg_read(A_STAT, 32'd2, 1'b1, {name, "_rd_stat"});
        $display("run %s: num=%0d gap=%0d abort=%0d pairs=%0d end_rel=%0d",
                 name, num, gap, abort_off, seen_cyc.size(), end_rel);
    endtask

    task automatic reset_mid_gap();
        cfg_write(A_PROTO, 32'h22);
        cfg_write(A_LEN, 32'd100);
        cfg_write(A_NUM, 32'd5);
        cfg_write(A_GAP, 32'd4);
        cin_gac_data    = mkword(OP_WR, A_CTRL, 32'h1);
        cin_gac_data_wr = 1'b1;
        @(negedge clk);
        cin_gac_data_wr = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rstgap_in_run", 256'(gac2scm_sent_start), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_seen();
        check_val("rstgap_md_wr", 256'(out_gac_md_wr), 256'(0));
        check_val("rstgap_phv_wr", 256'(out_gac_phv_wr), 256'(0));
        check_val("rstgap_md", out_gac_md, 256'(0));
        check_val("rstgap_phv", 256'(out_gac_phv[31:0]), 256'(0));
        check_val("rstgap_start", 256'(gac2scm_sent_start), 256'(0));
        check_val("rstgap_end", 256'(gac2scm_sent_end), 256'(0));
        check_val("rstgap_cout_wr", 256'(cout_gac_data_wr), 256'(0));
        check_val("rstgap_cout", 256'(cout_gac_data), 256'(0));
        repeat (8) @(negedge clk);
        check_val("rstgap_no_pairs", 256'(seen_cyc.size()), 256'(0));
        check_val("rstgap_idle_end", 256'(gac2scm_sent_end), 256'(0));
        cnt_model = 0;
        $display("reset mid-gap done");
    endtask

    initial begin
        int num, gap, ab;
        logic [133:0] w;
        repeat (3) @(negedge clk);
        check_val("rst_md_wr", 256'(out_gac_md_wr), 256'(0));
        check_val("rst_phv_wr", 256'(out_gac_phv_wr), 256'(0));
        check_val("rst_md", out_gac_md, 256'(0));
        check_val("rst_start", 256'(gac2scm_sent_start), 256'(0));
        check_val("rst_end", 256'(gac2scm_sent_end), 256'(0));
        check_val("rst_cout_wr", 256'(cout_gac_data_wr), 256'(0));
        check_val("rst_cout", 256'(cout_gac_data), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_cout_wr", 256'(cout_gac_data_wr), 256'(0));

        do_run("basic", 8'h01, 12'd64, 3, 0, -1, -1, 0, 0);

        // abort+start together while DONE: abort wins, nothing restarts
        clear_seen();
        cfg_write(A_CTRL, 32'h3);
        repeat (4) @(negedge clk);
        check_val("abst_no_pairs", 256'(seen_cyc.size()), 256'(0));
        check_val("abst_end", 256'(gac2scm_sent_end), 256'(1));

        do_run("gap", 8'h11, 12'd128, 2, 2, -1, -1, 0, 0);
        do_run("bp", 8'h06, 12'd1500, 6, 0, -1, -1, 0, 3);
        do_run("abort", 8'h11, 12'd64, 10, 0, 2, -1, 0, 0);
        do_run("zero", 8'h01, 12'd64, 0, 0, -1, -1, 0, 0);
        do_run("restart", 8'h33, 12'd77, 5, 1, -1, 3, 0, 0);

        cfg_read(A_UNK, 32'd0, 1'b0, "rd_unknown");
        w = mkword(3'b111, A_CNT, 32'h1234);
        cfg_xfer(w, 1'b1, w, "other_op");
        w = mkword(OP_WR, A_PROTO, 32'hAA);
        cfg_xfer(w, 1'b0, w, "not_ready");

        reset_mid_gap();
        do_run("post_rst", 8'h01, 12'd64, 3, 0, -1, -1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            num = int'($urandom_range(8, 1));
            gap = int'($urandom_range(3, 0));
            ab  = ($urandom_range(3) == 0) ? int'($urandom_range(12, 2)) : -1;
            do_run("rnd", 8'($urandom), 12'($urandom), num, gap, ab, -1,
                   int'($urandom_range(40, 0)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gac_pkt_gen.md
# gac_pkt_gen

Traffic generator that originates MD/PHV pairs toward the statistics collector (scm) and drives the `gac2scm_sent_start` / `gac2scm_sent_end` window signals it consumes. Programmed and polled through the standard 134-bit configuration packet chain, which it also forwards to the next module. It sits immediately upstream of scm in the pipeline, honouring scm's almost-full back-pressure.

## Interface
- `SMID`, 8'd5: source module ID written into MD[95:88].
- `DST_MID`, 8'd7: destination module ID written into MD[87:80]; matches scm's LMID.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `out_gac_md`  out  256  generated metadata.
- `out_gac_md_wr`  out  1  MD write strobe.
- `in_gac_md_alf`  in  1  downstream MD almost-full.
- `out_gac_phv`  out  1024  generated PHV.
- `out_gac_phv_wr`  out  1  PHV write strobe, always coincident with `out_gac_md_wr`.
- `in_gac_phv_alf`  in  1  downstream PHV almost-full.
- `gac2scm_sent_start`  out  1  level; high while a run is in progress.
- `gac2scm_sent_end`  out  1  level; high from run completion until the next start.
- `cin_gac_data`  in  134  config packet in.
- `cin_gac_data_wr`  in  1  config valid.
- `cout_gac_ready`  out  1  equals `cin_gac_ready`, combinational.
- `cout_gac_data`  out  134  config packet out, registered.
- `cout_gac_data_wr`  out  1  config valid out.
- `cin_gac_ready`  in  1  downstream config ready.

## Operation
- **Config acceptance:** a word is accepted when `cin_gac_data_wr && cin_gac_ready`. Opcode is [126:124]; address is [95:64].
- **Writes (opcode 3'b010):**
  - 0x70000010 proto[7:0]
  - 0x70000011 pkt_len[11:0]
  - 0x70000012 pkt_num[31:0]
  - 0x70000013 gap[15:0]
  - 0x70000014 ctrl: bit0 start, self-clearing; bit1 abort, self-clearing
  - The write is forwarded unchanged.
- **Reads (opcode 3'b001):**
  - 0x70000018 returns sent_cnt.
  - 0x70000019 returns {30'b0, sent_end, sent_start}.
  - The response is {[133:128], 4'b1011, [123:32], value}.
  - Any other address is forwarded unchanged.
- **Other opcodes:** forwarded unchanged.
- **Timestamp:** free-running 32-bit cycle counter; wraps modulo 2^32.
- **MD format:**
  - [255:109] = 0; [108] = 0
  - [107:96] pkt_len; [95:88] SMID; [87:80] DST_MID; [79:72] proto
  - [71:64] = 0; [63:32] seq; [31:0] timestamp at emission
- **PHV format:** [1023:32] = 0; [31:0] seq.
- **FSM IDLE:** both window signals low. On start: if pkt_num = 0, go to DONE; else clear seq and sent_cnt, go to SEND.
- **FSM SEND:** `sent_start` = 1. When `in_gac_md_alf || in_gac_phv_alf` is low, emit one pair (1-cycle strobes), then increment seq and sent_cnt. Next state:
  - sent_cnt+1 = pkt_num → DONE
  - else gap ≠ 0 → GAP, loading gap_cnt = gap
  - else stay in SEND (back-to-back pairs)
- **FSM GAP:** decrement gap_cnt; at 1, return to SEND. Inserts exactly `gap` idle cycles.
- **FSM DONE:** `sent_start` = 0, `sent_end` = 1. A new start clears `sent_end` and behaves as in IDLE.
- **Abort:** forces DONE from SEND or GAP with no further pairs. If abort and start arrive in the same word, abort wins.
- **Start while SEND/GAP:** ignored.
- **proto/pkt_len/gap writes during a run:** apply from the next emitted pair. pkt_num is latched at start.

## Timing
- **Reset:** all outputs 0; all registers 0; FSM in IDLE.
- **Reset mid-run:** stops emission next cycle; no partial pair is emitted.
- **Config path:** `cout_gac_data` / `cout_gac_data_wr` have 1-cycle latency. `cout_gac_data_wr` is 0 in cycles with no accepted word.
- **Start latency:** start accepted at cycle N → state SEND and `sent_start` = 1 at N+1 → first strobe at N+2 if alf is low at N+1.
- **Back-pressure:** alf is sampled registered-path. With alf high, no strobe is issued and state is held.
- **Run end:** the last strobe is at cycle M; `sent_start` falls and `sent_end` rises at M+1. The two are never high together.
- **Counter widths:** seq and sent_cnt are 32-bit and wrap silently.

## Structure
- **`gac_pkg`:** MD field offsets, config addresses, opcodes (CFG_WR = 3'b010, CFG_RD = 3'b001, CFG_RESP = 4'b1011), and the FSM state encoding (IDLE, SEND, GAP, DONE).
- **Sub-module `gac_cfg_regs`:** config decode, register file, read-response mux, and forwarding register. It exports start/abort pulses and register values.
- **Top level:** contains the FSM, timestamp, and MD/PHV formatting.

## Test plan
- **Basic run:** proto=0x01, pkt_len=64, pkt_num=3, gap=0, start → 3 consecutive strobes with seq 0,1,2 and MD[87:80]=7, MD[107:96]=64. `sent_end` rises the cycle after the 3rd strobe.
- **Gap:** gap=2, pkt_num=2 → strobes exactly 3 cycles apart.
- **Back-pressure:** hold `in_gac_md_alf` high for 5 cycles mid-run → no strobes during the hold; seq continues without a skip; total pair count is unchanged.
- **Abort:** abort after the 1st of 10 packets → no further strobes; reading 0x70000018 returns 1 with response nibble 4'b1011; 0x70000019 returns 2.
- **Edge cases:** pkt_num=0 start → zero strobes and `sent_end` at N+1. Start while SEND → ignored. Unknown read address 0x70000000 → forwarded unchanged.
- **Reset mid-GAP:** `rst` high for 1 cycle → all outputs 0 and FSM in IDLE; a subsequent start restarts seq at 0.
